// File: rtl/mc_port_responder.sv
// mc_port_responder: target end of the MC request/response interface.
// Requests are queued, serviced in order against a 64-bit scratchpad RAM,
// and answered through a response FIFO whose head is a registered output.
module mc_port_responder #(
  parameter int RTNCTL_WIDTH = 32,
  parameter int MEM_AW       = 10,
  parameter int FIFO_DEPTH   = 8,
  parameter int SKID         = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mc_rq_vld,
  input  logic [2:0]              mc_rq_cmd,
  input  logic [3:0]              mc_rq_scmd,
  input  logic [1:0]              mc_rq_size,
  input  logic [47:0]             mc_rq_vadr,
  input  logic [63:0]             mc_rq_data,
  input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  output logic                    mc_rq_stall,
  input  logic                    mc_rq_flush,
  output logic                    mc_rs_vld,
  output logic [2:0]              mc_rs_cmd,
  output logic [3:0]              mc_rs_scmd,
  output logic [63:0]             mc_rs_data,
  output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  input  logic                    mc_rs_stall,
  output logic                    mc_rs_flush_cmplt,
  output logic                    err_ovf,
  output logic                    err_cmd
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int WCW = $clog2(2 * FIFO_DEPTH + 3) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STALL_TH = CW'(FIFO_DEPTH - SKID - 1);
  localparam logic [CW-1:0] RS_LIMIT = CW'(FIFO_DEPTH - 2);

  typedef enum logic [2:0] {CMD_RD = 3'd1, CMD_WR = 3'd2} rq_cmd_e;
  typedef enum logic [2:0] {RS_RD_DATA = 3'd2, RS_WR_CMPLT = 3'd3} rs_cmd_e;

  typedef struct packed {
    logic                    wr;
    logic [MEM_AW-1:0]       idx;
    logic [63:0]             data;
    logic [RTNCTL_WIDTH-1:0] rtn;
  } rq_ent_t;

  typedef struct packed {
    logic [2:0]              cmd;
    logic [63:0]             data;
    logic [RTNCTL_WIDTH-1:0] rtn;
  } rs_ent_t;

  // Request FIFO
  rq_ent_t           rq_mem [FIFO_DEPTH];
  logic [PW-1:0]     rq_wp, rq_rp;
  logic [CW-1:0]     rq_cnt, rq_cnt_nxt;
  rq_ent_t           rq_in, rq_head;
  logic              rq_cmd_ok, rq_full, rq_push, rq_pop;

  // Service stage and RAM
  logic [63:0]       ram [2**MEM_AW];
  logic [63:0]       rd_q;
  logic              stage_vld, stage_wr;
  logic [RTNCTL_WIDTH-1:0] stage_rtn;
  rs_ent_t           stage_ent;

  // Response FIFO and registered head
  rs_ent_t           rs_mem [FIFO_DEPTH];
  logic [PW-1:0]     rs_wp, rs_rp;
  logic [CW-1:0]     rs_cnt;
  logic              rs_push, rs_pop, out_take;
  rs_ent_t           out_q;
  logic              out_vld;

  // Flush tracking
  logic [WCW-1:0]    wr_out;
  logic              wr_in, wr_done, flush_pending, flush_done, flush_pulse;

  logic              unused_bits;
  assign unused_bits = ^{mc_rq_scmd, mc_rq_size, mc_rq_vadr[47:MEM_AW+3], mc_rq_vadr[2:0]};

  // Request decode, FIFO control and response-side handshake
  always_comb begin
    rq_cmd_ok  = (mc_rq_cmd == CMD_RD) || (mc_rq_cmd == CMD_WR);
    rq_in.wr   = (mc_rq_cmd == CMD_WR);
    rq_in.idx  = mc_rq_vadr[MEM_AW+2:3];
    rq_in.data = mc_rq_data;
    rq_in.rtn  = mc_rq_rtnctl;
    rq_head    = rq_mem[rq_rp];
    rq_full    = (rq_cnt == DEPTH_C);
    rq_pop     = (rq_cnt != '0) && ((rs_cnt + CW'(stage_vld)) <= RS_LIMIT);
    // a full FIFO still accepts when it pops in the same cycle
    rq_push    = mc_rq_vld && rq_cmd_ok && (!rq_full || rq_pop);
    rq_cnt_nxt = rq_cnt + CW'(rq_push) - CW'(rq_pop);

    stage_ent.cmd  = stage_wr ? RS_WR_CMPLT : RS_RD_DATA;
    stage_ent.data = stage_wr ? '0 : rd_q;
    stage_ent.rtn  = stage_rtn;

    out_take = !out_vld || !mc_rs_stall;
    rs_pop   = out_take && (rs_cnt != '0);
    // stage result bypasses the FIFO when it would otherwise be the head
    rs_push  = stage_vld && !(out_take && (rs_cnt == '0));

    wr_in      = rq_push && rq_in.wr;
    wr_done    = out_vld && !mc_rs_stall && (out_q.cmd == RS_WR_CMPLT);
    flush_done = flush_pending && (wr_out == '0);
  end

  // FIFO storage, scratchpad write and synchronous read (not reset)
  always_ff @(posedge clk) begin
    if (rq_push) rq_mem[rq_wp] <= rq_in;
    if (rs_push) rs_mem[rs_wp] <= stage_ent;
    if (rq_pop) begin
      if (rq_head.wr) ram[rq_head.idx] <= rq_head.data;
      else            rd_q <= ram[rq_head.idx];
    end
  end

  // Control state: pointers, counters, stage, output head, flush, errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_wp         <= '0;
      rq_rp         <= '0;
      rq_cnt        <= '0;
      rs_wp         <= '0;
      rs_rp         <= '0;
      rs_cnt        <= '0;
      stage_vld     <= 1'b0;
      stage_wr      <= 1'b0;
      stage_rtn     <= '0;
      out_vld       <= 1'b0;
      out_q         <= '0;
      mc_rq_stall   <= 1'b0;
      wr_out        <= '0;
      flush_pending <= 1'b0;
      flush_pulse   <= 1'b0;
      err_ovf       <= 1'b0;
      err_cmd       <= 1'b0;
    end else begin
      if (rq_push) rq_wp <= rq_wp + PW'(1);
      if (rq_pop)  rq_rp <= rq_rp + PW'(1);
      rq_cnt      <= rq_cnt_nxt;
      mc_rq_stall <= (rq_cnt_nxt >= STALL_TH);

      stage_vld <= rq_pop;
      if (rq_pop) begin
        stage_wr  <= rq_head.wr;
        stage_rtn <= rq_head.rtn;
      end

      if (rs_push) rs_wp <= rs_wp + PW'(1);
      if (rs_pop)  rs_rp <= rs_rp + PW'(1);
      rs_cnt <= rs_cnt + CW'(rs_push) - CW'(rs_pop);

      if (out_take) begin
        if (rs_cnt != '0) begin
          out_q   <= rs_mem[rs_rp];
          out_vld <= 1'b1;
        end else if (stage_vld) begin
          out_q   <= stage_ent;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end

      wr_out        <= wr_out + WCW'(wr_in) - WCW'(wr_done);
      flush_pending <= mc_rq_flush || (flush_pending && !flush_done);
      flush_pulse   <= flush_done;

      if (mc_rq_vld && !rq_cmd_ok)           err_cmd <= 1'b1;
      if (mc_rq_vld && rq_cmd_ok && !rq_push) err_ovf <= 1'b1;
    end
  end

  assign mc_rs_vld         = out_vld;
  assign mc_rs_cmd         = out_q.cmd;
  assign mc_rs_scmd        = '0;
  assign mc_rs_data        = out_q.data;
  assign mc_rs_rtnctl      = out_q.rtn;
  assign mc_rs_flush_cmplt = flush_pulse;

endmodule

// File: tb/tb_mc_port_responder.sv
// Scoreboard bench for mc_port_responder: stimulus pushes expected responses
// computed from a word-addressed memory model; a monitor pops and compares.
module tb_mc_port_responder;

  logic        clk, rst_n;
  logic        rq_vld, rq_flush, rs_stall;
  logic [2:0]  rq_cmd;
  logic [3:0]  rq_scmd;
  logic [1:0]  rq_size;
  logic [47:0] rq_vadr;
  logic [63:0] rq_data;
  logic [31:0] rq_rtn;
  logic        rq_stall, rs_vld, flush_cmplt, e_ovf, e_cmd;
  logic [2:0]  rs_cmd;
  logic [3:0]  rs_scmd;
  logic [63:0] rs_data;
  logic [31:0] rs_rtn;

  mc_port_responder #(
    .RTNCTL_WIDTH(32), .MEM_AW(10), .FIFO_DEPTH(8), .SKID(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mc_rq_vld(rq_vld), .mc_rq_cmd(rq_cmd), .mc_rq_scmd(rq_scmd),
    .mc_rq_size(rq_size), .mc_rq_vadr(rq_vadr), .mc_rq_data(rq_data),
    .mc_rq_rtnctl(rq_rtn), .mc_rq_stall(rq_stall), .mc_rq_flush(rq_flush),
    .mc_rs_vld(rs_vld), .mc_rs_cmd(rs_cmd), .mc_rs_scmd(rs_scmd),
    .mc_rs_data(rs_data), .mc_rs_rtnctl(rs_rtn), .mc_rs_stall(rs_stall),
    .mc_rs_flush_cmplt(flush_cmplt), .err_ovf(e_ovf), .err_cmd(e_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [63:0] data;
    logic [31:0] rtn;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model [int];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          flush_pulses = 0;
  bit          rand_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic int word_of(input logic [47:0] vadr);
    return int'((vadr / 8) % 1024);
  endfunction

  // Monitor: every delivered response must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rs_vld && !rs_stall) begin
      chk("rsp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_cmd", rs_cmd, e.cmd);
        chk("rsp_data", rs_data, e.data);
        chk("rsp_rtnctl", rs_rtn, e.rtn);
        chk("rsp_scmd", rs_scmd, 0);
      end
    end
  end

  always @(negedge clk)
    if (rst_n && flush_cmplt) flush_pulses++;

  always @(posedge clk)
    if (rand_stall) begin
      #1 rs_stall = ($urandom_range(0, 2) == 0);
    end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [47:0] vadr,
                       input logic [63:0] data, input logic [31:0] rtn,
                       input bit expect_rsp);
    exp_t e;
    int   w;
    rq_vld  = 1'b1;
    rq_cmd  = cmd;
    rq_scmd = '0;
    rq_size = 2'd3;
    rq_vadr = vadr;
    rq_data = data;
    rq_rtn  = rtn;
    if (expect_rsp) begin
      w = word_of(vadr);
      e.rtn = rtn;
      if (cmd == 3'd2) begin
        model[w] = data;
        e.cmd  = 3'd3;
        e.data = 64'd0;
      end else begin
        e.cmd  = 3'd2;
        e.data = model[w];
      end
      exp_q.push_back(e);
    end
    cyc();
    rq_vld   = 1'b0;
    rq_flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rs_vld"}, rs_vld, 0);
    chk({tag, "_rs_cmd"}, rs_cmd, 0);
    chk({tag, "_rs_data"}, rs_data, 0);
    chk({tag, "_rs_rtnctl"}, rs_rtn, 0);
    chk({tag, "_rq_stall"}, rq_stall, 0);
    chk({tag, "_flush_cmplt"}, flush_cmplt, 0);
    chk({tag, "_err_ovf"}, e_ovf, 0);
    chk({tag, "_err_cmd"}, e_cmd, 0);
  endtask

  initial begin
    bit seen;
    int skid, cnt, w;
    logic [63:0] d;

    rst_n = 1'b0; rq_vld = 1'b0; rq_flush = 1'b0; rs_stall = 1'b0;
    rq_cmd = '0; rq_scmd = '0; rq_size = '0; rq_vadr = '0; rq_data = '0; rq_rtn = '0;
    repeat (3) cyc();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    cyc();

    // Flush with nothing outstanding completes two cycles later
    rq_flush = 1'b1;
    cyc();
    rq_flush = 1'b0;
    chk("idle_flush_c1", flush_cmplt, 0);
    cyc();
    chk("idle_flush_c2", flush_cmplt, 1);
    cyc();
    chk("idle_flush_c3", flush_cmplt, 0);

    // WR then RD of the same word, with first-response latency
    issue(3'd2, 48'h40, 64'hDEADBEEF, 32'd5, 1);
    issue(3'd1, 48'h40, 64'h0, 32'd6, 1);
    chk("latency_c2", rs_vld, 0);
    cyc();
    chk("latency_c3", rs_vld, 1);
    drain("drain_basic");

    // Address wrap modulo 2^(MEM_AW+3) bytes
    issue(3'd2, 48'h2008, 64'h11, 32'd7, 1);
    issue(3'd1, 48'h0008, 64'h0, 32'd8, 1);
    drain("drain_wrap");

    // Back-to-back under response stall, honouring rq_stall plus skid
    rs_stall = 1'b1;
    seen = 0; skid = 0; cnt = 0;
    while (cnt < 40) begin
      if (rq_stall) seen = 1;
      if (seen && skid == 2) break;
      if (seen) skid++;
      if (cnt % 2 == 0)
        issue(3'd2, 48'(64 + cnt / 2) << 3, {$urandom, $urandom}, 32'(100 + cnt), 1);
      else
        issue(3'd1, 48'(64 + cnt / 2) << 3, 64'h0, 32'(100 + cnt), 1);
      cnt++;
    end
    repeat (4) cyc();
    chk("skid_stall_seen", seen, 1);
    chk("skid_no_ovf", e_ovf, 0);
    chk("skid_at_least_8", cnt >= 8, 1);
    rs_stall = 1'b0;
    drain("drain_skid");

    // Flush covering three writes, the last captured with the flush
    rs_stall = 1'b1;
    flush_pulses = 0;
    issue(3'd2, 48'h300, 64'hA1, 32'd201, 1);
    issue(3'd2, 48'h308, 64'hA2, 32'd202, 1);
    rq_flush = 1'b1;
    issue(3'd2, 48'h310, 64'hA3, 32'd203, 1);
    repeat (10) cyc();
    chk("flush_held", flush_pulses, 0);
    rs_stall = 1'b0;
    drain("drain_flush");
    chk("flush_not_early", flush_pulses, 0);
    repeat (4) cyc();
    chk("flush_once", flush_pulses, 1);

    // Randomized traffic over aliased addresses with random backpressure
    for (int i = 0; i < 8; i++)
      issue(3'd2, 48'(32 + i) << 3, {$urandom, $urandom}, 32'(300 + i), 1);
    rand_stall = 1;
    for (int i = 0; i < 80; i++) begin
      w = 0;
      if ($urandom_range(0, 3) == 0) cyc();
      while (rq_stall && w < 200) begin
        cyc();
        w++;
      end
      if (w >= 200) chk("rand_rq_stall_timeout", w, 0);
      d = {$urandom, $urandom};
      issue($urandom_range(0, 1) ? 3'd2 : 3'd1,
            (48'($urandom_range(0, 15)) << 13) | (48'(32 + $urandom_range(0, 7)) << 3)
              | 48'($urandom_range(0, 7)),
            d, $urandom, 1);
    end
    rand_stall = 0;
    cyc();
    rs_stall = 1'b0;
    drain("drain_random");

    // Unsupported command: no response, sticky err_cmd
    issue(3'd4, 48'h40, 64'h0, 32'd999, 0);
    repeat (6) cyc();
    chk("err_cmd_set", e_cmd, 1);
    chk("err_ovf_clear", e_ovf, 0);

    // Overflow by ignoring rq_stall, then reset mid-operation
    rs_stall = 1'b1;
    for (int i = 0; i < 24; i++)
      issue(3'd1, 48'h100, 64'h0, 32'(500 + i), 0);
    chk("err_ovf_set", e_ovf, 1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    exp_q.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    rs_stall = 1'b0;
    repeat (20) cyc();
    chk("no_stale", exp_q.size(), 0);
    issue(3'd2, 48'h5A8, 64'h0123456789ABCDEF, 32'd77, 1);
    issue(3'd1, 48'h5A8, 64'h0, 32'd78, 1);
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
